// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: arbitrates the single register-file write port between ALU
// writebacks (no back-pressure, always win the port) and load writebacks
// (valid/ready, buffered in a small FIFO). Queued entries are invalidated by
// younger ALU writes to the same register, forwarded to two read ports, and a
// stall request is raised when the queue head has been starved too long.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_alu_valid/addr/data              ALU writeback request
//   i_mem_valid/addr/data, o_mem_ready load writeback request (handshake)
//   o_write_en/addr/data               register-file write port
//   i_rd_addrN, o_fwd_hitN, o_fwd_dataN  queue forwarding for read port N
//   o_alu_stall                        request to withhold ALU writebacks
//   o_proto_err                        sticky: ALU write seen while stalled
module regs_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alu_valid,
    input  logic [ADDR_W-1:0] i_alu_addr,
    input  logic [XLEN-1:0]   i_alu_data,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [XLEN-1:0]   i_mem_data,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [XLEN-1:0]   o_write_data,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    output logic              o_fwd_hit1,
    output logic [XLEN-1:0]   o_fwd_data1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_fwd_hit2,
    output logic [XLEN-1:0]   o_fwd_data2,
    output logic              o_alu_stall,
    output logic              o_proto_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {StRun, StStall} state_e;

    logic              r_valid [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [XLEN-1:0]   r_data  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;
    logic              r_proto_err;
    state_e            r_state;

    state_e            w_state_nxt;
    logic [STV_W-1:0]  w_starve_nxt;
    logic [PTR_W-1:0]  w_slot [DEPTH];
    logic              w_alu_wr;
    logic              w_empty;
    logic              w_head_live;
    logic              w_push;
    logic              w_push_valid;
    logic              w_pop;
    logic              w_blocked;

    assign w_alu_wr    = !i_rst && i_alu_valid && (i_alu_addr != '0);
    assign w_empty     = (r_count == '0);
    assign w_head_live = !w_empty && r_valid[r_head];
    assign o_mem_ready = (r_count < CNT_W'(DEPTH));
    assign w_push      = !i_rst && i_mem_valid && o_mem_ready && (i_mem_addr != '0);
    // A load accepted alongside an ALU write to the same register is the older
    // write, so it enters the queue already dead.
    assign w_push_valid = !(w_alu_wr && (i_alu_addr == i_mem_addr));
    // Dead heads drain freely; live heads only when the ALU leaves the port idle.
    assign w_pop       = !i_rst && !w_empty && (!r_valid[r_head] || !w_alu_wr);
    assign w_blocked   = w_head_live && w_alu_wr;

    // Write port: ALU first, otherwise the live queue head.
    always_comb begin
        o_write_en   = 1'b0;
        o_write_addr = '0;
        o_write_data = '0;
        if (w_alu_wr) begin
            o_write_en   = 1'b1;
            o_write_addr = i_alu_addr;
            o_write_data = i_alu_data;
        end else if (!i_rst && w_head_live) begin
            o_write_en   = 1'b1;
            o_write_addr = r_addr[r_head];
            o_write_data = r_data[r_head];
        end
    end

    // Slot holding the i-th oldest entry; DEPTH is a power of two so it wraps.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_slot[i] = r_head + PTR_W'(i);
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        o_fwd_hit1  = 1'b0;
        o_fwd_data1 = '0;
        o_fwd_hit2  = 1'b0;
        o_fwd_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) && r_valid[w_slot[i]]) begin
                if ((i_rd_addr1 != '0) && (r_addr[w_slot[i]] == i_rd_addr1)) begin
                    o_fwd_hit1  = 1'b1;
                    o_fwd_data1 = r_data[w_slot[i]];
                end
                if ((i_rd_addr2 != '0) && (r_addr[w_slot[i]] == i_rd_addr2)) begin
                    o_fwd_hit2  = 1'b1;
                    o_fwd_data2 = r_data[w_slot[i]];
                end
            end
        end
    end

    // Starvation counter saturates at the limit while stalled.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || w_empty) begin
            w_starve_nxt = '0;
        end else if (w_blocked && (r_starve < STV_W'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_proto_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_alu_wr && (r_addr[i] == i_alu_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= w_push_valid;
                r_addr[r_tail]  <= i_mem_addr;
                r_data[r_tail]  <= i_mem_data;
                r_tail          <= r_tail + 1'b1;
            end
            r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_starve    <= w_starve_nxt;
            r_proto_err <= r_proto_err || (i_alu_valid && o_alu_stall);
        end
    end

    // Stall FSM: state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall FSM: next state. Leaving STALL needs the starved head to pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:   if (w_starve_nxt == STV_W'(STARVE_LIMIT)) w_state_nxt = StStall;
            StStall: if (w_pop) w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    // Stall FSM: outputs.
    always_comb begin
        o_alu_stall = (r_state == StStall);
    end

    assign o_proto_err = r_proto_err;

endmodule
